// File: rtl/cmp_event_detector.sv
// Debounced alarm from comparator L/E/G flags, with rise/fall pulses and an illegal-flag strobe.
// Optional: define CMP_EVT_COUNT_EN to add a saturating 16-bit count of alarm rises (evt_count).
//
// state    | meaning
// IDLE     | alarm low, no "above" streak in progress
// ARMING   | alarm low, counting consecutive "above" samples
// ALARM    | alarm high, no "below" streak in progress
// CLEARING | alarm high, counting consecutive "below" samples
module cmp_event_detector #(
   parameter int SET_CNT   = 3,
   parameter int CLR_CNT   = 2,
   parameter bit INCLUSIVE = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        L,
   input  logic        E,
   input  logic        G,
   output logic        alarm,
   output logic        rise_pulse,
   output logic        fall_pulse,
   output logic        flag_err,
`ifdef CMP_EVT_COUNT_EN
   output logic [15:0] evt_count,
`endif
   output logic [1:0]  state
);

   localparam int MAX_CNT = (SET_CNT > CLR_CNT) ? SET_CNT : CLR_CNT;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] SET_TC = CW'(SET_CNT - 1);
   localparam logic [CW-1:0] CLR_TC = CW'(CLR_CNT - 1);
   localparam logic [CW-1:0] ONE    = CW'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ARMING   = 2'b01,
      ALARM    = 2'b10,
      CLEARING = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          alarm_q, alarm_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic          err_q, err_d;
   logic          one_hot, accept, above, below;

   assign one_hot = (L ^ E ^ G) & ~(L & E & G);
   assign accept  = in_valid & one_hot;
   assign above   = G | (INCLUSIVE & E);
   assign below   = L | (~INCLUSIVE & E);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (accept) begin
         unique case (state_q)
            IDLE: begin
               if (above) begin
                  if (SET_CNT == 1) begin
                     state_d = ALARM;
                  end else begin
                     state_d = ARMING;
                     cnt_d   = ONE;
                  end
               end
            end
            ARMING: begin
               if (above) begin
                  if (cnt_q == SET_TC) begin
                     state_d = ALARM;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + ONE;
                  end
               end else if (below) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            end
            ALARM: begin
               if (below) begin
                  if (CLR_CNT == 1) begin
                     state_d = IDLE;
                  end else begin
                     state_d = CLEARING;
                     cnt_d   = ONE;
                  end
               end
            end
            CLEARING: begin
               if (below) begin
                  if (cnt_q == CLR_TC) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + ONE;
                  end
               end else if (above) begin
                  state_d = ALARM;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs derive from the next state so the alarm moves on the edge that accepts the sample.
   always_comb begin
      alarm_d = (state_d == ALARM) || (state_d == CLEARING);
      rise_d  = alarm_d & ~alarm_q;
      fall_d  = ~alarm_d & alarm_q;
      err_d   = in_valid & ~one_hot;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         alarm_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         err_q   <= err_d;
      end
   end

   assign alarm      = alarm_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign flag_err   = err_q;
   assign state      = state_q;

`ifdef CMP_EVT_COUNT_EN
   logic [15:0] evt_q, evt_d;

   always_comb begin
      evt_d = evt_q;
      if (rise_d && (evt_q != 16'hFFFF)) begin
         evt_d = evt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_q <= '0;
      end else begin
         evt_q <= evt_d;
      end
   end

   assign evt_count = evt_q;
`endif

endmodule

// File: tb/tb_cmp_event_detector.sv
// Self-checking bench for cmp_event_detector: exclusive (default), inclusive and SET/CLR=1 instances.
module tb_cmp_event_detector;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic L = 1'b0, E = 1'b0, G = 1'b0;

   logic       a0, rp0, fp0, er0;
   logic [1:0] st0;
   logic       a1, rp1, fp1, er1;
   logic [1:0] st1;
   logic       a2, rp2, fp2, er2;
   logic [1:0] st2;
`ifdef CMP_EVT_COUNT_EN
   logic [15:0] evt0, evt1, evt2;
   int exp_evt = 0;
`endif

   always #5 clk = ~clk;

   cmp_event_detector #(.SET_CNT(3), .CLR_CNT(2), .INCLUSIVE(1'b0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .L(L), .E(E), .G(G),
      .alarm(a0), .rise_pulse(rp0), .fall_pulse(fp0), .flag_err(er0),
`ifdef CMP_EVT_COUNT_EN
      .evt_count(evt0),
`endif
      .state(st0));

   cmp_event_detector #(.SET_CNT(3), .CLR_CNT(2), .INCLUSIVE(1'b1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .L(L), .E(E), .G(G),
      .alarm(a1), .rise_pulse(rp1), .fall_pulse(fp1), .flag_err(er1),
`ifdef CMP_EVT_COUNT_EN
      .evt_count(evt1),
`endif
      .state(st1));

   cmp_event_detector #(.SET_CNT(1), .CLR_CNT(1), .INCLUSIVE(1'b0)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .L(L), .E(E), .G(G),
      .alarm(a2), .rise_pulse(rp2), .fall_pulse(fp2), .flag_err(er2),
`ifdef CMP_EVT_COUNT_EN
      .evt_count(evt2),
`endif
      .state(st2));

   typedef struct {
      logic       r, v, l, e, g;
      logic       a, rp, fp, er;
      logic [1:0] st;
      logic       a1;
      logic [1:0] st1;
   } vec_t;

   typedef struct {
      logic       a, rp, fp, er;
      logic [1:0] st;
      logic       a1;
      logic [1:0] st1;
      logic       r;
   } exp_t;

   typedef struct {
      logic       a, rp, fp;
      logic [1:0] st;
   } exp2_t;

   vec_t  vecs[$];
   exp_t  sb[$];
   exp2_t sb2[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, want);
      end
   endtask

   task automatic add(input logic r, v, l, e, g, a, rp, fp, er, input logic [1:0] st,
                      input logic a1x, input logic [1:0] st1x);
      vec_t t;
      t.r = r; t.v = v; t.l = l; t.e = e; t.g = g;
      t.a = a; t.rp = rp; t.fp = fp; t.er = er; t.st = st;
      t.a1 = a1x; t.st1 = st1x;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic r, v, l, e, g);
      rst = r; in_valid = v; L = l; E = e; G = g;
   endtask

   // Main instances: push expectation at drive time, pop and compare after the edge.
   task automatic run_one(input int idx, input vec_t t);
      exp_t x, y;
      drive(t.r, t.v, t.l, t.e, t.g);
      x.a = t.a; x.rp = t.rp; x.fp = t.fp; x.er = t.er; x.st = t.st;
      x.a1 = t.a1; x.st1 = t.st1; x.r = t.r;
      sb.push_back(x);
      @(posedge clk);
      #1;
      y = sb.pop_front();
      chk("alarm", idx, {15'd0, a0}, {15'd0, y.a});
      chk("rise_pulse", idx, {15'd0, rp0}, {15'd0, y.rp});
      chk("fall_pulse", idx, {15'd0, fp0}, {15'd0, y.fp});
      chk("flag_err", idx, {15'd0, er0}, {15'd0, y.er});
      chk("state", idx, {14'd0, st0}, {14'd0, y.st});
      chk("incl_alarm", idx, {15'd0, a1}, {15'd0, y.a1});
      chk("incl_state", idx, {14'd0, st1}, {14'd0, y.st1});
`ifdef CMP_EVT_COUNT_EN
      if (y.r) exp_evt = 0;
      else if (y.rp && exp_evt < 16'hFFFF) exp_evt++;
      chk("evt_count", idx, evt0, exp_evt[15:0]);
`endif
   endtask

   task automatic run_two(input int idx, input logic r, v, l, e, g,
                          input logic a, rp, fp, input logic [1:0] st);
      exp2_t x, y;
      drive(r, v, l, e, g);
      x.a = a; x.rp = rp; x.fp = fp; x.st = st;
      sb2.push_back(x);
      @(posedge clk);
      #1;
      y = sb2.pop_front();
      chk("s1_alarm", idx, {15'd0, a2}, {15'd0, y.a});
      chk("s1_rise", idx, {15'd0, rp2}, {15'd0, y.rp});
      chk("s1_fall", idx, {15'd0, fp2}, {15'd0, y.fp});
      chk("s1_state", idx, {14'd0, st2}, {14'd0, y.st});
   endtask

   initial begin
      //   r v l e g   a rp fp er st    a1 st1
      add(1,0,0,0,0, 0,0,0,0,2'd0, 0,2'd0);
      add(1,1,0,0,1, 0,0,0,0,2'd0, 0,2'd0);
      for (int i = 0; i < 5; i++) add(0,0,0,0,1, 0,0,0,0,2'd0, 0,2'd0);
      // three G -> rise
      add(0,1,0,0,1, 0,0,0,0,2'd1, 0,2'd1);
      add(0,1,0,0,1, 0,0,0,0,2'd1, 0,2'd1);
      add(0,1,0,0,1, 1,1,0,0,2'd2, 1,2'd2);
      add(0,0,0,0,0, 1,0,0,0,2'd2, 1,2'd2);
      // clear: L G L L
      add(0,1,1,0,0, 1,0,0,0,2'd3, 1,2'd3);
      add(0,1,0,0,1, 1,0,0,0,2'd2, 1,2'd2);
      add(0,1,1,0,0, 1,0,0,0,2'd3, 1,2'd3);
      add(0,1,1,0,0, 0,0,1,0,2'd0, 0,2'd0);
      add(0,0,0,0,0, 0,0,0,0,2'd0, 0,2'd0);
      // G G L G G L: streak broken
      add(0,1,0,0,1, 0,0,0,0,2'd1, 0,2'd1);
      add(0,1,0,0,1, 0,0,0,0,2'd1, 0,2'd1);
      add(0,1,1,0,0, 0,0,0,0,2'd0, 0,2'd0);
      add(0,1,0,0,1, 0,0,0,0,2'd1, 0,2'd1);
      add(0,1,0,0,1, 0,0,0,0,2'd1, 0,2'd1);
      add(0,1,1,0,0, 0,0,0,0,2'd0, 0,2'd0);
      // E x3: below when exclusive, above when inclusive
      add(0,1,0,1,0, 0,0,0,0,2'd0, 0,2'd1);
      add(0,1,0,1,0, 0,0,0,0,2'd0, 0,2'd1);
      add(0,1,0,1,0, 0,0,0,0,2'd0, 1,2'd2);
      add(0,1,1,0,0, 0,0,0,0,2'd0, 1,2'd3);
      add(0,1,1,0,0, 0,0,0,0,2'd0, 0,2'd0);
      // illegal flags hold the count
      add(0,1,0,0,1, 0,0,0,0,2'd1, 0,2'd1);
      add(0,1,0,1,1, 0,0,0,1,2'd1, 0,2'd1);
      add(0,0,1,1,1, 0,0,0,0,2'd1, 0,2'd1);
      add(0,1,0,0,0, 0,0,0,1,2'd1, 0,2'd1);
      add(0,1,0,0,1, 0,0,0,0,2'd1, 0,2'd1);
      add(0,1,0,0,1, 1,1,0,0,2'd2, 1,2'd2);
      add(0,1,1,1,1, 1,0,0,1,2'd2, 1,2'd2);
      // reset while CLEARING: no fall pulse
      add(0,1,1,0,0, 1,0,0,0,2'd3, 1,2'd3);
      add(1,1,1,0,0, 0,0,0,0,2'd0, 0,2'd0);
      add(0,0,0,0,0, 0,0,0,0,2'd0, 0,2'd0);

      for (int i = 0; i < vecs.size(); i++) run_one(i, vecs[i]);

      // Valid gaps do not break or advance the streak.
      begin
         vec_t t;
         t = '{r:0, v:1, l:0, e:0, g:1, a:0, rp:0, fp:0, er:0, st:2'd1, a1:0, st1:2'd1};
         run_one(100, t);
         t.v = 0;
         for (int k = 0; k < 3; k++) run_one(101 + k, t);
         t.v = 1;
         run_one(104, t);
         t.v = 0;
         run_one(105, t);
         t.v = 1; t.a = 1; t.rp = 1; t.st = 2'd2; t.a1 = 1; t.st1 = 2'd2;
         run_one(106, t);
         t.v = 0; t.rp = 0;
         run_one(107, t);
      end

      // SET_CNT=CLR_CNT=1: alarm follows each accepted sample directly.
      run_two(200, 1,0,0,0,0, 0,0,0,2'd0);
      run_two(201, 0,1,0,0,1, 1,1,0,2'd2);
      run_two(202, 0,1,0,0,1, 1,0,0,2'd2);
      run_two(203, 0,1,1,0,0, 0,0,1,2'd0);
      run_two(204, 0,1,0,1,0, 0,0,0,2'd0);
      run_two(205, 0,1,1,1,0, 0,0,0,2'd0);
      run_two(206, 0,1,0,0,1, 1,1,0,2'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
